// File: rtl/cal_pkg.sv
// Shared types and constants for the calendar date counter.
// Provides month numbers, field typedefs and month-length constants.
package cal_pkg;

  typedef logic [6:0] cal_day_t;
  typedef logic [6:0] cal_month_t;
  typedef logic [6:0] cal_year_t;
  typedef logic [2:0] cal_wday_t;

  localparam cal_month_t JAN = 7'd1;
  localparam cal_month_t FEB = 7'd2;
  localparam cal_month_t MAR = 7'd3;
  localparam cal_month_t APR = 7'd4;
  localparam cal_month_t MAY = 7'd5;
  localparam cal_month_t JUN = 7'd6;
  localparam cal_month_t JUL = 7'd7;
  localparam cal_month_t AUG = 7'd8;
  localparam cal_month_t SEP = 7'd9;
  localparam cal_month_t OCT = 7'd10;
  localparam cal_month_t NOV = 7'd11;
  localparam cal_month_t DEC = 7'd12;

  localparam logic [4:0] DAYS_31       = 5'd31;
  localparam logic [4:0] DAYS_30       = 5'd30;
  localparam logic [4:0] DAYS_FEB      = 5'd28;
  localparam logic [4:0] DAYS_FEB_LEAP = 5'd29;

  localparam cal_year_t YEAR_MAX = 7'd99;
  localparam cal_wday_t WDAY_MAX = 3'd6;

endpackage

// File: rtl/cal_month_len.sv
// Combinational month-length lookup.
// Configuration macro: LEAP_YEAR_EN (February has 29 days when year[1:0] == 0).
// Ports:
//   month_i  month number; anything outside 1..12 yields length 0
//   year_i   year 0..99 (2000..2099)
//   len_o    number of days in the month
module cal_month_len
  import cal_pkg::*;
(
  input  cal_month_t  month_i,
  input  cal_year_t   year_i,
  output logic [4:0]  len_o
);

  logic [4:0] feb_len;

`ifdef LEAP_YEAR_EN
  // Every fourth year is leap across 2000..2099 (2000 itself is a leap year).
  assign feb_len = (year_i[1:0] == 2'b00) ? DAYS_FEB_LEAP : DAYS_FEB;
  logic unused_year_bits;
  assign unused_year_bits = ^year_i[6:2];
`else
  assign feb_len = DAYS_FEB;
  logic unused_year_bits;
  assign unused_year_bits = ^year_i;
`endif

  always_comb begin
    len_o = 5'd0;
    case (month_i)
      JAN, MAR, MAY, JUL, AUG, OCT, DEC: len_o = DAYS_31;
      APR, JUN, SEP, NOV:                len_o = DAYS_30;
      FEB:                               len_o = feb_len;
      default:                           len_o = 5'd0;
    endcase
  end

endmodule

// File: rtl/calendar_date_counter.sv
// Day/month/year/weekday counter advanced by a midnight day tick.
// Configuration macro: LEAP_YEAR_EN (enables 29 February in years with year[1:0] == 0).
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset, highest priority
//   day_tick_i     one-cycle pulse: advance one day
//   set_en_i       one-cycle pulse: load set_* fields (wins over day_tick_i)
//   set_day_i .. set_wday_i   date to load
//   day_o, month_o, year_o, wday_o   current date (registered)
//   month_wrap_o   pulse when day wraps to 1
//   year_wrap_o    pulse when year wraps 99 -> 0
//   set_err_o      pulse when a set request carried an invalid date
module calendar_date_counter
  import cal_pkg::*;
#(
  parameter int unsigned RST_YEAR = 0,
  parameter int unsigned RST_WDAY = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       day_tick_i,
  input  logic       set_en_i,
  input  logic [6:0] set_day_i,
  input  logic [6:0] set_month_i,
  input  logic [6:0] set_year_i,
  input  logic [2:0] set_wday_i,
  output logic [6:0] day_o,
  output logic [6:0] month_o,
  output logic [6:0] year_o,
  output logic [2:0] wday_o,
  output logic       month_wrap_o,
  output logic       year_wrap_o,
  output logic       set_err_o
);

  cal_day_t   day_q,   day_d;
  cal_month_t month_q, month_d;
  cal_year_t  year_q,  year_d;
  cal_wday_t  wday_q,  wday_d;
  logic       month_wrap_q, month_wrap_d;
  logic       year_wrap_q,  year_wrap_d;
  logic       set_err_q,    set_err_d;

  logic [4:0] cur_len;
  logic [4:0] set_len;
  logic       set_valid;
  logic       day_wrap;

  cal_month_len u_cur_len (
    .month_i (month_q),
    .year_i  (year_q),
    .len_o   (cur_len)
  );

  cal_month_len u_set_len (
    .month_i (set_month_i),
    .year_i  (set_year_i),
    .len_o   (set_len)
  );

  // An invalid month gives set_len == 0, so the day range check rejects it too.
  assign set_valid = (set_month_i >= JAN) && (set_month_i <= DEC) &&
                     (set_day_i != 7'd0) && (set_day_i <= {2'b00, set_len}) &&
                     (set_year_i <= YEAR_MAX) && (set_wday_i <= WDAY_MAX);

  // Covers the normal end of month and recovery from an out-of-range state.
  assign day_wrap = (day_q >= {2'b00, cur_len}) || (month_q > DEC);

  always_comb begin
    day_d        = day_q;
    month_d      = month_q;
    year_d       = year_q;
    wday_d       = wday_q;
    month_wrap_d = 1'b0;
    year_wrap_d  = 1'b0;
    set_err_d    = 1'b0;

    if (set_en_i) begin
      if (set_valid) begin
        day_d   = set_day_i;
        month_d = set_month_i;
        year_d  = set_year_i;
        wday_d  = set_wday_i;
      end else begin
        set_err_d = 1'b1;
      end
    end else if (day_tick_i) begin
      wday_d = (wday_q >= WDAY_MAX) ? 3'd0 : wday_q + 3'd1;
      if (day_wrap) begin
        day_d        = 7'd1;
        month_wrap_d = 1'b1;
        if (month_q >= DEC) begin
          month_d = JAN;
          if (month_q == DEC) begin
            if (year_q >= YEAR_MAX) begin
              year_d      = 7'd0;
              year_wrap_d = 1'b1;
            end else begin
              year_d = year_q + 7'd1;
            end
          end
        end else begin
          month_d = month_q + 7'd1;
        end
      end else begin
        day_d = day_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      day_q        <= 7'd1;
      month_q      <= JAN;
      year_q       <= 7'(RST_YEAR);
      wday_q       <= 3'(RST_WDAY);
      month_wrap_q <= 1'b0;
      year_wrap_q  <= 1'b0;
      set_err_q    <= 1'b0;
    end else begin
      day_q        <= day_d;
      month_q      <= month_d;
      year_q       <= year_d;
      wday_q       <= wday_d;
      month_wrap_q <= month_wrap_d;
      year_wrap_q  <= year_wrap_d;
      set_err_q    <= set_err_d;
    end
  end

  assign day_o        = day_q;
  assign month_o      = month_q;
  assign year_o       = year_q;
  assign wday_o       = wday_q;
  assign month_wrap_o = month_wrap_q;
  assign year_wrap_o  = year_wrap_q;
  assign set_err_o    = set_err_q;

endmodule

// File: tb/tb_calendar_date_counter.sv
// Scoreboard bench for calendar_date_counter: each driven cycle pushes the
// hand-computed registered outputs; a monitor pops and compares after each edge.
module tb_calendar_date_counter;

`ifdef LEAP_YEAR_EN
  localparam bit Leap = 1'b1;
`else
  localparam bit Leap = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       day_tick;
  logic       set_en;
  logic [6:0] set_day, set_month, set_year;
  logic [2:0] set_wday;
  logic [6:0] day, month, year;
  logic [2:0] wday;
  logic       month_wrap, year_wrap, set_err;

  typedef struct {
    string      name;
    logic [6:0] d;
    logic [6:0] m;
    logic [6:0] y;
    logic [2:0] w;
    logic       mw;
    logic       yw;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  calendar_date_counter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .day_tick_i   (day_tick),
    .set_en_i     (set_en),
    .set_day_i    (set_day),
    .set_month_i  (set_month),
    .set_year_i   (set_year),
    .set_wday_i   (set_wday),
    .day_o        (day),
    .month_o      (month),
    .year_o       (year),
    .wday_o       (wday),
    .month_wrap_o (month_wrap),
    .year_wrap_o  (year_wrap),
    .set_err_o    (set_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and queue the expected result.
  task automatic step(input string name, input logic r, input logic s, input logic t,
                      input logic [6:0] sd, input logic [6:0] sm, input logic [6:0] sy,
                      input logic [2:0] sw,
                      input logic [6:0] ed, input logic [6:0] em, input logic [6:0] ey,
                      input logic [2:0] ew, input logic emw, input logic eyw,
                      input logic eerr);
    exp_t e;
    @(negedge clk);
    rst = r; set_en = s; day_tick = t;
    set_day = sd; set_month = sm; set_year = sy; set_wday = sw;
    e.name = name; e.d = ed; e.m = em; e.y = ey; e.w = ew;
    e.mw = emw; e.yw = eyw; e.err = eerr;
    sb.push_back(e);
  endtask

  // Monitor: outputs are registered, so sample 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if (day !== e.d || month !== e.m || year !== e.y || wday !== e.w ||
            month_wrap !== e.mw || year_wrap !== e.yw || set_err !== e.err) begin
          n_fail++;
          $display("FAIL %s: got %0d/%0d/%0d wd%0d mw%0b yw%0b err%0b, want %0d/%0d/%0d wd%0d mw%0b yw%0b err%0b",
                   e.name, day, month, year, wday, month_wrap, year_wrap, set_err,
                   e.d, e.m, e.y, e.w, e.mw, e.yw, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; set_en = 1'b0; day_tick = 1'b0;
    set_day = '0; set_month = '0; set_year = '0; set_wday = '0;

    //    name          r  s  t   sd  sm   sy  sw   ed  em  ey  ew mw yw err
    step("reset",       1, 0, 0,  0,  0,   0, 0,   1,  1,  0, 6, 0, 0, 0);
    step("tick_basic",  0, 0, 1,  0,  0,   0, 0,   2,  1,  0, 0, 0, 0, 0);
    step("set_jan31",   0, 1, 0, 31,  1,  24, 3,  31,  1, 24, 3, 0, 0, 0);
    step("tick_jan31",  0, 0, 1,  0,  0,   0, 0,   1,  2, 24, 4, 1, 0, 0);
    step("idle_mw_off", 0, 0, 0,  0,  0,   0, 0,   1,  2, 24, 4, 0, 0, 0);
    step("set_feb28",   0, 1, 0, 28,  2,  24, 1,  28,  2, 24, 1, 0, 0, 0);
    if (Leap) begin
      step("tick_feb28", 0, 0, 1,  0,  0,   0, 0,  29,  2, 24, 2, 0, 0, 0);
      step("tick_feb29", 0, 0, 1,  0,  0,   0, 0,   1,  3, 24, 3, 1, 0, 0);
      step("set_feb29",  0, 1, 0, 29,  2,  24, 0,  29,  2, 24, 0, 0, 0, 0);
      step("set_f29_23", 0, 1, 0, 29,  2,  23, 1,  29,  2, 24, 0, 0, 0, 1);
    end else begin
      step("tick_feb28", 0, 0, 1,  0,  0,   0, 0,   1,  3, 24, 2, 1, 0, 0);
      step("tick_mar1",  0, 0, 1,  0,  0,   0, 0,   2,  3, 24, 3, 0, 0, 0);
      step("set_feb29",  0, 1, 0, 29,  2,  24, 0,   2,  3, 24, 3, 0, 0, 1);
      step("set_f29_23", 0, 1, 0, 29,  2,  23, 1,   2,  3, 24, 3, 0, 0, 1);
    end
    step("set_dec31",   0, 1, 0, 31, 12,  99, 5,  31, 12, 99, 5, 0, 0, 0);
    step("tick_y99",    0, 0, 1,  0,  0,   0, 0,   1,  1,  0, 6, 1, 1, 0);
    step("idle_pulses", 0, 0, 0,  0,  0,   0, 0,   1,  1,  0, 6, 0, 0, 0);
    step("set_apr31",   0, 1, 0, 31,  4,  10, 0,   1,  1,  0, 6, 0, 0, 1);
    step("idle_err_off",0, 0, 0,  0,  0,   0, 0,   1,  1,  0, 6, 0, 0, 0);
    step("set_month0",  0, 1, 0, 15,  0,  10, 0,   1,  1,  0, 6, 0, 0, 1);
    step("set_month13", 0, 1, 0, 15, 13,  10, 0,   1,  1,  0, 6, 0, 0, 1);
    step("set_day0",    0, 1, 0,  0,  5,  10, 0,   1,  1,  0, 6, 0, 0, 1);
    step("set_year100", 0, 1, 0,  5,  5, 100, 0,   1,  1,  0, 6, 0, 0, 1);
    step("set_wday7",   0, 1, 0,  5,  5,  10, 7,   1,  1,  0, 6, 0, 0, 1);
    step("set_apr30",   0, 1, 0, 30,  4,  10, 2,  30,  4, 10, 2, 0, 0, 0);
    step("tick_apr30",  0, 0, 1,  0,  0,   0, 0,   1,  5, 10, 3, 1, 0, 0);
    step("set_dec31_20",0, 1, 0, 31, 12,  20, 4,  31, 12, 20, 4, 0, 0, 0);
    step("tick_newyear",0, 0, 1,  0,  0,   0, 0,   1,  1, 21, 5, 1, 0, 0);
    step("set_and_tick",0, 1, 1, 10,  6,  20, 1,  10,  6, 20, 1, 0, 0, 0);
    step("rst_and_set", 1, 1, 0, 10,  6,  20, 1,   1,  1,  0, 6, 0, 0, 0);
    step("set_wd6",     0, 1, 0, 31,  1,  24, 6,  31,  1, 24, 6, 0, 0, 0);
    step("tick_wd_wrap",0, 0, 1,  0,  0,   0, 0,   1,  2, 24, 0, 1, 0, 0);
    step("tail_idle",   0, 0, 0,  0,  0,   0, 0,   1,  2, 24, 0, 0, 0, 0);

    @(negedge clk);
    rst = 1'b0; set_en = 1'b0; day_tick = 1'b0;
    // The monitor must have drained the queue within a couple of edges.
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
